// File: rtl/f_btb.sv
// Fetch-stage BTB with 2-bit direction counters: lookup is combinational on pc, updates land at the clock edge.
// No backpressure: every upd_en strobe is accepted, one per cycle; a lookup sees pre-update contents.
module f_btb #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pc,
  output logic [12:0] pc_predicted,
  output logic        pred_hit,
  input  logic        upd_en,
  input  logic [12:0] upd_pc,
  input  logic [12:0] upd_jumppc,
  input  logic        upd_taken,
  input  logic        fail_predict,
  output logic [15:0] mispredict_cnt
);

  localparam int TAG_W = 13 - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [12:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t tbl [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  entry_t           rd_ent;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  entry_t           wr_ent;
  logic             wr_hit;

  assign rd_idx = pc[IDX_W-1:0];
  assign rd_tag = pc[12:IDX_W];
  assign rd_ent = tbl[rd_idx];

  assign pred_hit     = rd_ent.valid && (rd_ent.tag == rd_tag);
  assign pc_predicted = (pred_hit && rd_ent.ctr[1]) ? rd_ent.target : pc + 13'd1;

  assign wr_idx = upd_pc[IDX_W-1:0];
  assign wr_tag = upd_pc[12:IDX_W];
  assign wr_ent = tbl[wr_idx];
  assign wr_hit = wr_ent.valid && (wr_ent.tag == wr_tag);

  // Counters reset to weakly-not-taken so a fresh allocation starts one step above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        if (upd_taken) begin
          if (wr_ent.ctr != 2'b11) tbl[wr_idx].ctr <= wr_ent.ctr + 2'd1;
          tbl[wr_idx].target <= upd_jumppc;
        end else if (wr_ent.ctr != 2'b00) begin
          tbl[wr_idx].ctr <= wr_ent.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        tbl[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: upd_jumppc, ctr: 2'b10};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (fail_predict && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_f_btb.sv
// Directed bench for f_btb: hand-computed lookups after allocate, hysteresis, aliasing and reset.
module tb_f_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] pc;
  logic [12:0] pc_predicted;
  logic        pred_hit;
  logic        upd_en;
  logic [12:0] upd_pc;
  logic [12:0] upd_jumppc;
  logic        upd_taken;
  logic        fail_predict;
  logic [15:0] mispredict_cnt;

  int n_pass = 0;
  int n_total = 0;

  f_btb #(.IDX_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_predicted   (pc_predicted),
    .pred_hit       (pred_hit),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_jumppc     (upd_jumppc),
    .upd_taken      (upd_taken),
    .fail_predict   (fail_predict),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One update strobe across a single rising edge; returns 1 time unit after the edge.
  task automatic upd(input logic [12:0] a, input logic [12:0] tgt, input logic tk);
    upd_en     = 1'b1;
    upd_pc     = a;
    upd_jumppc = tgt;
    upd_taken  = tk;
    @(posedge clk);
    #1;
    upd_en = 1'b0;
  endtask

  task automatic look(input string tag, input logic [12:0] a, input logic hit, input logic [12:0] exp_pc);
    pc = a;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_pc"}, {19'd0, pc_predicted}, {19'd0, exp_pc});
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 13'h0010;
    upd_en = 1'b0;
    upd_pc = '0;
    upd_jumppc = '0;
    upd_taken = 1'b0;
    fail_predict = 1'b0;
    #2;
    look("in_reset", 13'h0010, 1'b0, 13'h0011);
    check("cnt_reset", {16'd0, mispredict_cnt}, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    look("post_reset", 13'h0010, 1'b0, 13'h0011);
    look("wrap", 13'h1FFF, 1'b0, 13'h0000);

    upd(13'h0024, 13'h0100, 1'b1);
    look("alloc", 13'h0024, 1'b1, 13'h0100);

    upd(13'h0024, 13'h0100, 1'b0);
    look("hyst_wnt", 13'h0024, 1'b1, 13'h0025);
    upd(13'h0024, 13'h0100, 1'b1);
    upd(13'h0024, 13'h0100, 1'b1);
    upd(13'h0024, 13'h0100, 1'b0);
    look("hyst_wt", 13'h0024, 1'b1, 13'h0100);

    upd(13'h0034, 13'h0200, 1'b1);
    look("alias_old", 13'h0024, 1'b0, 13'h0025);
    look("alias_new", 13'h0034, 1'b1, 13'h0200);

    // Lookup and allocate at the same index in one cycle: no bypass.
    pc = 13'h0040;
    upd_en = 1'b1;
    upd_pc = 13'h0040;
    upd_jumppc = 13'h0300;
    upd_taken = 1'b1;
    #1;
    check("same_cyc_hit", {31'd0, pred_hit}, 32'd0);
    check("same_cyc_pc", {19'd0, pc_predicted}, 32'h0041);
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    look("same_next", 13'h0040, 1'b1, 13'h0300);

    upd_pc = 13'h0050;
    upd_jumppc = 13'h0444;
    upd_taken = 1'b1;
    @(posedge clk);
    #1;
    look("upd_en_low", 13'h0050, 1'b0, 13'h0051);

    upd(13'h0060, 13'h0555, 1'b0);
    look("miss_nt", 13'h0060, 1'b0, 13'h0061);

    fail_predict = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_3", {16'd0, mispredict_cnt}, 32'd3);
    repeat (65531) @(posedge clk);
    #1;
    check("cnt_fffe", {16'd0, mispredict_cnt}, 32'hFFFE);
    repeat (2) @(posedge clk);
    #1;
    check("cnt_sat", {16'd0, mispredict_cnt}, 32'hFFFF);
    fail_predict = 1'b0;

    // Asynchronous reset between edges clears everything at once.
    #1;
    rst_n = 1'b0;
    #1;
    check("cnt_async_rst", {16'd0, mispredict_cnt}, 32'd0);
    look("rst_0034", 13'h0034, 1'b0, 13'h0035);
    look("rst_0040", 13'h0040, 1'b0, 13'h0041);

    upd_en = 1'b1;
    upd_pc = 13'h0070;
    upd_jumppc = 13'h0777;
    upd_taken = 1'b1;
    fail_predict = 1'b1;
    @(posedge clk);
    #1;
    upd_en = 1'b0;
    fail_predict = 1'b0;
    rst_n = 1'b1;
    look("rst_discard", 13'h0070, 1'b0, 13'h0071);
    check("cnt_rst_hold", {16'd0, mispredict_cnt}, 32'd0);

    upd(13'h0080, 13'h0400, 1'b1);
    look("first_after_rst", 13'h0080, 1'b1, 13'h0400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/f_btb.md
# f_btb

Fetch-stage branch target buffer and direction predictor. Each cycle it looks up the fetch PC and returns the predicted next PC: the stored target when the entry hits and predicts taken, otherwise PC+1. The execute-stage PC calculator is the writer. It reports each resolved jump or branch (its PC, its computed jump target and its taken outcome) plus a misprediction flag. This block learns from those reports.

## Interface
- IDX_W, 4, index width; table holds 2^IDX_W entries; legal range 1..12
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  in  13  fetch PC (word address)
- pc_predicted  out  13  predicted next fetch PC
- pred_hit  out  1  lookup hit a valid entry with matching tag
- upd_en  in  1  execute stage reports a resolved jump/branch this cycle
- upd_pc  in  13  PC of the resolved instruction
- upd_jumppc  in  13  computed jump/branch target of that instruction
- upd_taken  in  1  instruction actually redirected (branch condition true, or jal/jalr)
- fail_predict  in  1  execute stage detected a misprediction this cycle
- mispredict_cnt  out  16  saturating count of cycles with fail_predict=1

## Operation
- Entry fields: valid (1), tag (13-IDX_W), target (13), ctr (2-bit saturating).
- Address split: index = pc[IDX_W-1:0], tag = pc[12:IDX_W]. Same split for upd_pc.
- Lookup (combinational on pc):
  - pred_hit = valid & (tag match).
  - pc_predicted = target when pred_hit & ctr[1], else pc + 1.
  - pc + 1 is 13-bit and wraps, so 13'h1FFF gives 13'h0000.
- Update (registered, only when upd_en=1):
  - Hit and upd_taken=1: ctr = min(ctr+1, 3); target <= upd_jumppc.
  - Hit and upd_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss and upd_taken=1: allocate, overwriting any occupant at that index. Set valid=1, tag=upd_pc tag, target=upd_jumppc, ctr=2'b10 (weakly taken).
  - Miss and upd_taken=0: no change.
- upd_en=0: table unchanged, whatever the other upd_* inputs hold.
- mispredict_cnt increments by 1 on each rising edge with fail_predict=1. It holds at 16'hFFFF. It is independent of upd_en.
- Counter encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately, without a clock edge):
  - All valid=0, all ctr=2'b01, all target/tag=0, mispredict_cnt=0.
  - Outputs during and after reset: pred_hit=0, pc_predicted=pc+1.
- Lookup latency: 0 cycles, purely combinational from pc and current table state.
- Update latency: written at the rising edge where upd_en=1. Visible to lookup from the following cycle.
- Simultaneous lookup and update to the same index in the same cycle: lookup returns pre-update contents. There is no write-through bypass.
- Reset asserted mid-operation: any pending update in that cycle is discarded. Table and counter are cleared regardless of upd_en or fail_predict.
- Release of rst_n: the first update can occur at the first rising edge with rst_n=1.
- Tag mismatch at a valid index is a miss: pred_hit=0, prediction is pc+1.
- Aliasing between PCs that share an index is resolved only by the tag compare.
- Only one update per cycle. No stall or handshake: upd_en is a single-cycle strobe per resolved instruction.

## Test plan
- Reset then lookup: rst_n=0 then 1, pc=13'h0010 -> pred_hit=0, pc_predicted=13'h0011. Also pc=13'h1FFF -> pc_predicted=13'h0000.
- Allocate: upd_en=1, upd_pc=13'h0024, upd_jumppc=13'h0100, upd_taken=1. Next cycle pc=13'h0024 -> pred_hit=1, pc_predicted=13'h0100.
- Hysteresis: after the allocate above, one not-taken update (ctr 10->01) -> pc_predicted=13'h0025. Two taken updates (01->10->11), then one not-taken (11->10) -> pc_predicted=13'h0100.
- Aliasing/replacement (IDX_W=4): allocate 13'h0024, then taken update at 13'h0034 with target 13'h0200. pc=13'h0024 -> pred_hit=0, pc_predicted=13'h0025. pc=13'h0034 -> pc_predicted=13'h0200.
- Same-cycle read/write: pc=upd_pc=13'h0040, taken allocate with target 13'h0300 -> that cycle pred_hit=0, pc_predicted=13'h0041. Next cycle pc_predicted=13'h0300.
- Mispredict counter and reset: fail_predict=1 for 3 edges -> mispredict_cnt=3. Forced to 16'hFFFE, 2 more edges -> 16'hFFFF. Assert rst_n=0 between edges -> mispredict_cnt=0 and all entries miss immediately.
